// File: rtl/multiword_add_pkg.sv
// Shared types and default sizing for the multi-word add controller.
package multiword_add_pkg;

  localparam int DEF_BIT_WIDTH = 4;
  localparam int DEF_NUM_WORDS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/adder_nbit.sv
// Narrow ripple adder shared by the word-serial controller.
// The carry-in comes from the controller's carry register.
module adder_nbit #(
  parameter int BIT_WIDTH = 4
) (
  input  logic [BIT_WIDTH-1:0] a,
  input  logic [BIT_WIDTH-1:0] b,
  input  logic                 carry_in,
  output logic [BIT_WIDTH-1:0] sum,
  output logic                 overflow
);

  assign {overflow, sum} = {1'b0, a} + {1'b0, b} + {{BIT_WIDTH{1'b0}}, carry_in};

endmodule

// File: rtl/multiword_add_ctrl.sv
// Word-serial wide adder: one adder_nbit is reused over NUM_WORDS cycles,
// least-significant word first, with the carry held between words.
// Optional macro SUBTRACT_EN adds a 'sub' input that selects A - B.
module multiword_add_ctrl
  import multiword_add_pkg::*;
#(
  parameter int BIT_WIDTH = DEF_BIT_WIDTH,
  parameter int NUM_WORDS = DEF_NUM_WORDS
) (
  input  logic                           clk,
  input  logic                           n_rst,
`ifdef SUBTRACT_EN
  input  logic                           sub,
`endif
  input  logic                           start,
  input  logic [BIT_WIDTH*NUM_WORDS-1:0] op_a,
  input  logic [BIT_WIDTH*NUM_WORDS-1:0] op_b,
  output logic                           busy,
  output logic                           done,
  output logic [BIT_WIDTH*NUM_WORDS-1:0] result,
  output logic                           overflow
);

  localparam int TW    = BIT_WIDTH * NUM_WORDS;
  localparam int CNT_W = $clog2(NUM_WORDS);
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NUM_WORDS - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               carry_q;
  logic [TW-1:0]      a_q, b_q;
  logic [TW-1:0]      acc_q;
  logic [TW-1:0]      result_q;
  logic               overflow_q;

  logic               accept;
  logic               last_word;
  logic [TW-1:0]      b_load;
  logic               carry_load;
  logic [BIT_WIDTH-1:0] word_sum;
  logic               word_carry;

  // A request is taken only when no operation is running (IDLE or DONE).
  assign accept    = start && (state_q != ADD);
  assign last_word = (state_q == ADD) && (cnt_q == LAST_WORD);

`ifdef SUBTRACT_EN
  // Subtraction is A + ~B + 1: invert B once at capture, seed the carry with 1.
  assign b_load     = sub ? ~op_b : op_b;
  assign carry_load = sub;
`else
  assign b_load     = op_b;
  assign carry_load = 1'b0;
`endif

  // The operand registers shift right each ADD cycle, so the low word is
  // always word[cnt] of the captured operand.
  adder_nbit #(
    .BIT_WIDTH (BIT_WIDTH)
  ) u_adder (
    .a        (a_q[BIT_WIDTH-1:0]),
    .b        (b_q[BIT_WIDTH-1:0]),
    .carry_in (carry_q),
    .sum      (word_sum),
    .overflow (word_carry)
  );

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = ADD;
      ADD:     if (last_word) state_d = DONE;
      DONE:    state_d = start ? ADD : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, per-word accumulation, carry chaining and result update.
  // NOTE: every datapath register, the accumulator included, is reset so an
  // abandoned operation leaves no stale words behind.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q      <= '0;
      carry_q    <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      result_q   <= '0;
      overflow_q <= 1'b0;
    end else if (accept) begin
      a_q     <= op_a;
      b_q     <= b_load;
      carry_q <= carry_load;
      cnt_q   <= '0;
    end else if (state_q == ADD) begin
      a_q     <= a_q >> BIT_WIDTH;
      b_q     <= b_q >> BIT_WIDTH;
      // New word enters at the top; after NUM_WORDS cycles word 0 is lowest.
      acc_q   <= {word_sum, acc_q[TW-1:BIT_WIDTH]};
      carry_q <= word_carry;
      if (last_word) begin
        result_q   <= {word_sum, acc_q[TW-1:BIT_WIDTH]};
        overflow_q <= word_carry;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign busy     = (state_q == ADD);
  assign done     = (state_q == DONE);
  assign result   = result_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_multiword_add_ctrl.sv
// Self-checking bench for multiword_add_ctrl (default 4 x 4-bit words).
// Table vectors, hand-written corner sequences and random operations are
// compared against plain-arithmetic expectations.
module tb_multiword_add_ctrl;

  localparam int BW = 4;
  localparam int NW = 4;
  localparam int TW = BW * NW;

  typedef struct {
    logic [TW-1:0] a;
    logic [TW-1:0] b;
    logic          sub;
    logic [TW-1:0] exp_r;
    logic          exp_o;
  } vec_t;

  logic          clk;
  logic          n_rst;
  logic          start;
  logic [TW-1:0] op_a;
  logic [TW-1:0] op_b;
  logic          busy;
  logic          done;
  logic [TW-1:0] result;
  logic          overflow;
`ifdef SUBTRACT_EN
  logic          sub;
`endif

  int n_vec = 0;
  int n_err = 0;

  multiword_add_ctrl #(
    .BIT_WIDTH (BW),
    .NUM_WORDS (NW)
  ) dut (
    .clk      (clk),
    .n_rst    (n_rst),
`ifdef SUBTRACT_EN
    .sub      (sub),
`endif
    .start    (start),
    .op_a     (op_a),
    .op_b     (op_b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Wide-integer reference: plain sum or difference of the whole operands.
  function automatic logic [TW:0] model(input logic [TW-1:0] a, input logic [TW-1:0] b,
                                        input logic s);
    logic [TW:0] r;
    if (s) r = {(a >= b), TW'(a - b)};
    else   r = {1'b0, a} + {1'b0, b};
    return r;
  endfunction

  // One isolated operation: start for one cycle, scramble operands during
  // ADD, then check busy for NW cycles and the done cycle contents.
  task automatic run_op(input vec_t v, input string tag);
    @(negedge clk);
    start = 1'b1;
    op_a  = v.a;
    op_b  = v.b;
`ifdef SUBTRACT_EN
    sub   = v.sub;
`endif
    @(posedge clk); #1;
    start = 1'b0;
    op_a  = TW'($urandom);
    op_b  = TW'($urandom);
    for (int i = 0; i < NW; i++) begin
      @(negedge clk);
      check($sformatf("%s.busy%0d", tag, i), 32'(busy), 32'd1);
      check($sformatf("%s.nodone%0d", tag, i), 32'(done), 32'd0);
    end
    @(negedge clk);
    check({tag, ".done"}, 32'(done), 32'd1);
    check({tag, ".idle_busy"}, 32'(busy), 32'd0);
    check({tag, ".result"}, 32'(result), 32'(v.exp_r));
    check({tag, ".overflow"}, 32'(overflow), 32'(v.exp_o));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];
    vec_t v;
    logic [TW:0] m;

    vecs.push_back('{16'h1234, 16'h0FF0, 1'b0, 16'h2224, 1'b0});
    vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1});
    vecs.push_back('{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0});
    vecs.push_back('{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1});
    vecs.push_back('{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0});
    vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b1});
`ifdef SUBTRACT_EN
    vecs.push_back('{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0});
    vecs.push_back('{16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1});
    vecs.push_back('{16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1});
    vecs.push_back('{16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0});
`endif

    n_rst = 1'b0;
    start = 1'b0;
    op_a  = '0;
    op_b  = '0;
`ifdef SUBTRACT_EN
    sub   = 1'b0;
`endif

    // Reset state.
    #12;
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.result", 32'(result), 32'd0);
    check("rst.overflow", 32'(overflow), 32'd0);
    @(negedge clk);
    n_rst = 1'b1;

    // Table-driven vectors.
    for (int i = 0; i < vecs.size(); i++) run_op(vecs[i], $sformatf("vec%0d", i));

    // Start held high: ADD-time operand changes ignored, request taken in DONE.
    @(negedge clk);
    start = 1'b1;
    op_a  = 16'h0001;
    op_b  = 16'h0002;
    @(posedge clk); #1;
    op_a  = 16'h00FF;
    op_b  = 16'h0F00;
    for (int i = 0; i < NW; i++) begin
      @(negedge clk);
      check($sformatf("b2b.busy%0d", i), 32'(busy), 32'd1);
    end
    @(negedge clk);
    check("b2b.done1", 32'(done), 32'd1);
    check("b2b.result1", 32'(result), 32'h0003);
    check("b2b.ovf1", 32'(overflow), 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    op_a  = 16'hAAAA;
    op_b  = 16'h5555;
    for (int i = 0; i < NW; i++) begin
      @(negedge clk);
      check($sformatf("b2b.busy2_%0d", i), 32'(busy), 32'd1);
      check($sformatf("b2b.nodone2_%0d", i), 32'(done), 32'd0);
    end
    @(negedge clk);
    check("b2b.done2", 32'(done), 32'd1);
    check("b2b.result2", 32'(result), 32'h0FFF);
    @(negedge clk);
    check("b2b.idle_done", 32'(done), 32'd0);
    check("b2b.idle_busy", 32'(busy), 32'd0);

    // Start during ADD is ignored and not queued.
    @(negedge clk);
    start = 1'b1;
    op_a  = 16'h1111;
    op_b  = 16'h2222;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("busyreq.busy1", 32'(busy), 32'd1);
    @(negedge clk);
    start = 1'b1;
    op_a  = 16'h7777;
    op_b  = 16'h7777;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("busyreq.busy3", 32'(busy), 32'd1);
    @(negedge clk);
    check("busyreq.busy4", 32'(busy), 32'd1);
    @(negedge clk);
    check("busyreq.done", 32'(done), 32'd1);
    check("busyreq.result", 32'(result), 32'h3333);
    @(negedge clk);
    check("busyreq.no_queue_busy", 32'(busy), 32'd0);
    check("busyreq.no_queue_done", 32'(done), 32'd0);

    // Reset in the second ADD cycle abandons the operation.
    run_op('{16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b1}, "prerst");
    @(negedge clk);
    start = 1'b1;
    op_a  = 16'h0001;
    op_b  = 16'h0001;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #2;
    check("midrst.busy_before", 32'(busy), 32'd1);
    n_rst = 1'b0;
    #1;
    check("midrst.busy", 32'(busy), 32'd0);
    check("midrst.done", 32'(done), 32'd0);
    check("midrst.result", 32'(result), 32'd0);
    check("midrst.overflow", 32'(overflow), 32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    for (int i = 0; i < NW + 2; i++) begin
      @(negedge clk);
      check($sformatf("midrst.nodone%0d", i), 32'(done), 32'd0);
    end
    run_op('{16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0}, "postrst");

    // Random operations against the arithmetic model.
    for (int i = 0; i < 24; i++) begin
      v.a = TW'($urandom);
      v.b = TW'($urandom);
      if (i % 4 == 0) v.b = ~v.a + TW'($urandom_range(0, 1));
`ifdef SUBTRACT_EN
      v.sub = 1'($urandom);
`else
      v.sub = 1'b0;
`endif
      m       = model(v.a, v.b, v.sub);
      v.exp_r = m[TW-1:0];
      v.exp_o = m[TW];
      run_op(v, $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
